adc_acq_sequencer: RTL

Acquisition controller for the fast current-measurement ADC path. Generates the `ADC_acquire` strobe and FIFO clear for the pair-averaging front end. Runs configurable bursts of averaged words, either back-to-back or per external trigger, with programmable inter-burst gaps. Sits between the host/register block and the current-measurement averager/FIFO, in the `ADC_outclock` domain.

---
 rtl/adc_acq_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/adc_acq_sequencer.sv
// adc_acq_sequencer: burst acquisition controller driving the ADC_acquire strobe and FIFO clear.
// Optional FIFO fill guard: define ACQ_FIFO_GUARD_EN to stop a burst at a pair boundary on fifo_almost_full.
module adc_acq_sequencer #(
  parameter int CLR_CYCLES       = 4,
  parameter int TRIG_SYNC_STAGES = 2
) (
  input  logic        ADC_outclock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] cfg_burst_len,
  input  logic [15:0] cfg_n_bursts,
  input  logic [15:0] cfg_gap,
  input  logic        cfg_trig_mode,
  input  logic        ext_trigger,
  input  logic        fifo_almost_full,
  output logic        ADC_acquire,
  output logic        clr_fifo,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] bursts_done
);

  // state     | meaning
  // IDLE      | waiting for start
  // CLEAR     | clr_fifo held for CLR_CYCLES
  // WAIT_TRIG | one cycle (mode 0) or until synchronized trigger edge (mode 1)
  // ACQ       | ADC_acquire high, 2 cycles per averaged word
  // GAP       | programmable low time between bursts
  // DONE      | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_TRIG, S_ACQ, S_GAP, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0] len_q, nb_q, gap_q;
  logic        mode_q;
  logic [15:0] timer;
  logic [15:0] words_left;
  logic        phase;
  logic        stop_pend;
  logic        trig_hit;
  logic [TRIG_SYNC_STAGES-1:0] trig_sync;
  logic        trig_prev;
  logic        trig_rise;
  logic [15:0] bursts_q;

  logic pair_end, last_pair, run_end, stop_hit, guard_hit;
  logic acq_d, clr_d, busy_d, done_d;

  assign pair_end  = (state == S_ACQ) && phase;
  assign last_pair = pair_end && (words_left == 16'd1);
  assign run_end   = last_pair && (nb_q != 16'd0) && ((bursts_q + 16'd1) == nb_q);
  assign stop_hit  = stop || stop_pend;

`ifdef ACQ_FIFO_GUARD_EN
  logic ovf_q;
  assign guard_hit = pair_end && fifo_almost_full;

  always_ff @(posedge ADC_outclock) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (state == S_IDLE && start)
      ovf_q <= 1'b0;
    else if (guard_hit)
      ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  logic unused_fifo_flag;
  assign unused_fifo_flag = fifo_almost_full;
  assign guard_hit = 1'b0;
  assign overflow  = 1'b0;
`endif

  always_ff @(posedge ADC_outclock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (start) state_nxt = S_CLEAR;
      S_CLEAR:
        if (timer == 16'd1) state_nxt = stop_hit ? S_DONE : S_WAIT_TRIG;
      S_WAIT_TRIG:
        if (stop)                    state_nxt = S_DONE;
        else if (!mode_q || trig_hit) state_nxt = S_ACQ;
      S_ACQ:
        // exits only on a pair boundary so the acquire run is always even
        if (pair_end) begin
          if (run_end || stop_hit || guard_hit) state_nxt = S_DONE;
          else if (last_pair) state_nxt = (gap_q != 16'd0) ? S_GAP : S_WAIT_TRIG;
        end
      S_GAP:
        if (stop)                 state_nxt = S_DONE;
        else if (timer == 16'd1)  state_nxt = S_WAIT_TRIG;
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ADC_outclock) begin
    if (reset) begin
      len_q      <= 16'd0;
      nb_q       <= 16'd0;
      gap_q      <= 16'd0;
      mode_q     <= 1'b0;
      timer      <= 16'd0;
      words_left <= 16'd0;
      phase      <= 1'b0;
      stop_pend  <= 1'b0;
      trig_hit   <= 1'b0;
      trig_sync  <= '0;
      trig_prev  <= 1'b0;
      trig_rise  <= 1'b0;
      bursts_q   <= 16'd0;
    end else begin
      trig_sync <= {trig_sync[TRIG_SYNC_STAGES-2:0], ext_trigger};
      trig_prev <= trig_sync[TRIG_SYNC_STAGES-1];
      trig_rise <= trig_sync[TRIG_SYNC_STAGES-1] && !trig_prev;
      // edges are only remembered while waiting; anything earlier is dropped
      trig_hit  <= (state == S_WAIT_TRIG) && (state_nxt == S_WAIT_TRIG) && mode_q &&
                   (trig_hit || trig_rise);
      stop_pend <= (state == state_nxt) && (state == S_CLEAR || state == S_ACQ) &&
                   (stop_pend || stop);

      case (state)
        S_IDLE:
          if (start) begin
            len_q    <= (cfg_burst_len == 16'd0) ? 16'd1 : cfg_burst_len;
            nb_q     <= cfg_n_bursts;
            gap_q    <= cfg_gap;
            mode_q   <= cfg_trig_mode;
            bursts_q <= 16'd0;
            timer    <= 16'(CLR_CYCLES);
          end
        S_CLEAR, S_GAP:
          timer <= timer - 16'd1;
        S_ACQ: begin
          phase <= !phase;
          if (phase)     words_left <= words_left - 16'd1;
          if (last_pair) bursts_q   <= bursts_q + 16'd1;
        end
        default: ;
      endcase

      if (state_nxt == S_ACQ && state != S_ACQ) begin
        words_left <= len_q;
        phase      <= 1'b0;
      end
      if (state == S_ACQ && state_nxt == S_GAP)
        timer <= gap_q;
    end
  end

  always_comb begin
    acq_d  = (state_nxt == S_ACQ);
    clr_d  = (state_nxt == S_CLEAR);
    busy_d = (state_nxt != S_IDLE);
    done_d = (state_nxt == S_DONE);
  end

  always_ff @(posedge ADC_outclock) begin
    if (reset) begin
      ADC_acquire <= 1'b0;
      clr_fifo    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      ADC_acquire <= acq_d;
      clr_fifo    <= clr_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  assign bursts_done = bursts_q;

endmodule
